// File: rtl/gpu_pkg.sv
// Shared GPU-side constants and types for the RAM arbiter slice.
// Address/data widths, host port id and the index-width helper.
package gpu_pkg;

   localparam int GPU_ADDR_W = 20;
   localparam int GPU_DATA_W = 8;
   localparam int HOST_PORT  = 0;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                  vld;
      logic                  wr;
      logic [GPU_ADDR_W-1:0] addr;
      logic [GPU_DATA_W-1:0] data;
   } pend_t;

endpackage

// File: rtl/gpu_ram_arbiter_rr_select.sv
// Round-robin selector: first pending requester at or after ptr, one-hot grant.
// Indices are local (0..N-1); the caller maps them onto its own port numbers.
module rr_select
   import gpu_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         pend,
   input  logic [idx_w(N)-1:0]  ptr,
   output logic [N-1:0]         gnt
);

   logic found;
   int   idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!found && pend[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpu_ram_arbiter.sv
// Multi-port GPU RAM arbiter: host port 0 has absolute priority, the rest
// share the RAM round-robin; reads return through a tag pipeline.
module gpu_ram_arbiter
   import gpu_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int RD_LATENCY = 2
) (
   input  logic                             GPU_CLK,
   input  logic                             resetn,
   input  logic [NUM_PORTS-1:0]             req_rd,
   input  logic [NUM_PORTS-1:0]             req_wr,
   input  logic [GPU_ADDR_W*NUM_PORTS-1:0]  req_addr,
   input  logic [GPU_DATA_W*NUM_PORTS-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             port_busy,
   output logic [NUM_PORTS-1:0]             rd_rdy,
   output logic [GPU_DATA_W-1:0]            rData,
   output logic [NUM_PORTS-1:0]             overrun,
   output logic [GPU_ADDR_W-1:0]            ram_addr,
   output logic [GPU_DATA_W-1:0]            ram_wdata,
   output logic                             ram_wr_ena,
   output logic                             ram_rd_ena,
   input  logic [GPU_DATA_W-1:0]            ram_rData
);

   localparam int PW = idx_w(NUM_PORTS);
   localparam int RN = NUM_PORTS - 1;
   localparam int RW = idx_w(RN);

   pend_t [NUM_PORTS-1:0]     pend_q, pend_d;
   logic  [NUM_PORTS-1:0]     ovr_q, ovr_d;
   logic  [NUM_PORTS-1:0]     rd_rdy_q, rd_rdy_d;
   logic  [NUM_PORTS-1:0]     pend_vld, gnt_oh;
   logic  [RN-1:0]            rr_gnt;
   logic  [RW-1:0]            rr_ptr;
   logic  [PW-1:0]            ptr_q, ptr_d, gnt_idx;
   logic                      gnt_vld;
   pend_t                     gnt_req;
   logic  [GPU_ADDR_W-1:0]    ram_addr_q, ram_addr_d;
   logic  [GPU_DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
   logic  [GPU_DATA_W-1:0]    rdata_q, rdata_d;
   logic                      ram_wr_q, ram_wr_d, ram_rd_q, ram_rd_d;
   logic  [RD_LATENCY:0][PW-1:0] tag_q, tag_d;
   logic  [RD_LATENCY:0]      vld_pipe_q, vld_pipe_d;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) pend_vld[p] = pend_q[p].vld;
   end

   // Round-robin pointer is kept in port numbering (1..NUM_PORTS-1).
   assign rr_ptr = RW'(ptr_q - PW'(1));

   rr_select #(.N(RN)) u_rr (
      .pend (pend_vld[NUM_PORTS-1:1]),
      .ptr  (rr_ptr),
      .gnt  (rr_gnt)
   );

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (pend_vld[HOST_PORT]) begin
         gnt_vld = 1'b1;
         gnt_idx = PW'(HOST_PORT);
      end else begin
         for (int i = 0; i < RN; i++) begin
            if (rr_gnt[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = PW'(i + 1);
            end
         end
      end
      gnt_oh          = '0;
      gnt_oh[gnt_idx] = gnt_vld;
      gnt_req         = pend_q[gnt_idx];
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld && gnt_idx != PW'(HOST_PORT))
         ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? PW'(1) : gnt_idx + PW'(1);
   end

   // A port being granted this cycle frees its slot, so a same-cycle
   // request lands without counting as an overrun.
   always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_oh[p]) pend_d[p].vld = 1'b0;
         if (req_rd[p] || req_wr[p]) begin
            if (!pend_q[p].vld || gnt_oh[p]) begin
               pend_d[p].vld  = 1'b1;
               pend_d[p].wr   = req_wr[p];
               pend_d[p].addr = req_addr[GPU_ADDR_W*p +: GPU_ADDR_W];
               pend_d[p].data = req_wdata[GPU_DATA_W*p +: GPU_DATA_W];
            end else begin
               ovr_d[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wr_d    = 1'b0;
      ram_rd_d    = 1'b0;
      if (gnt_vld) begin
         ram_addr_d = gnt_req.addr;
         if (gnt_req.wr) begin
            ram_wdata_d = gnt_req.data;
            ram_wr_d    = 1'b1;
         end else begin
            ram_rd_d    = 1'b1;
         end
      end
   end

   // Stage k of the tag pipe is valid k cycles after the read strobe;
   // the last stage lines up with ram_rData.
   always_comb begin
      vld_pipe_d = {vld_pipe_q[RD_LATENCY-1:0], gnt_vld & ~gnt_req.wr};
      tag_d      = {tag_q[RD_LATENCY-1:0], gnt_idx};
      rd_rdy_d   = '0;
      rdata_d    = rdata_q;
      if (vld_pipe_q[RD_LATENCY]) begin
         rd_rdy_d[tag_q[RD_LATENCY]] = 1'b1;
         rdata_d                     = ram_rData;
      end
   end

   always_ff @(posedge GPU_CLK or negedge resetn) begin
      if (!resetn) begin
         pend_q      <= '0;
         ovr_q       <= '0;
         rd_rdy_q    <= '0;
         ptr_q       <= PW'(1);
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wr_q    <= 1'b0;
         ram_rd_q    <= 1'b0;
         rdata_q     <= '0;
         tag_q       <= '0;
         vld_pipe_q  <= '0;
      end else begin
         pend_q      <= pend_d;
         ovr_q       <= ovr_d;
         rd_rdy_q    <= rd_rdy_d;
         ptr_q       <= ptr_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wr_q    <= ram_wr_d;
         ram_rd_q    <= ram_rd_d;
         rdata_q     <= rdata_d;
         tag_q       <= tag_d;
         vld_pipe_q  <= vld_pipe_d;
      end
   end

   assign port_busy  = pend_vld;
   assign overrun    = ovr_q;
   assign rd_rdy     = rd_rdy_q;
   assign rData      = rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_wr_ena = ram_wr_q;
   assign ram_rd_ena = ram_rd_q;

endmodule
